// File: rtl/rvfi_pkg.sv
// Shared types and helpers for the RVFI retirement monitor.
// Holds the violation codes, the legal memory-mask patterns and the mask-legality function.
package rvfi_pkg;

   typedef enum logic [3:0] {
      NONE       = 4'd0,
      ORDER      = 4'd1,
      PC         = 4'd2,
      RS1        = 4'd3,
      RS2        = 4'd4,
      RD0        = 4'd5,
      MEM_MASK   = 4'd6,
      MEM_BOTH   = 4'd7,
      AFTER_HALT = 4'd8
   } err_code_t;

   localparam logic [3:0] MASK_NONE = 4'b0000;
   localparam logic [3:0] MASK_B0   = 4'b0001;
   localparam logic [3:0] MASK_B1   = 4'b0010;
   localparam logic [3:0] MASK_B2   = 4'b0100;
   localparam logic [3:0] MASK_B3   = 4'b1000;
   localparam logic [3:0] MASK_H0   = 4'b0011;
   localparam logic [3:0] MASK_H1   = 4'b1100;
   localparam logic [3:0] MASK_W    = 4'b1111;

   // A mask is legal when its shape is a byte/half/word and its lowest set lane matches addr[1:0].
   function automatic logic mask_ok(input logic [3:0] mask, input logic [1:0] addr);
      logic ok;
      ok = 1'b0;
      case (mask)
         MASK_NONE:                ok = 1'b1;
         MASK_B0, MASK_H0, MASK_W: ok = (addr == 2'd0);
         MASK_B1:                  ok = (addr == 2'd1);
         MASK_B2, MASK_H1:         ok = (addr == 2'd2);
         MASK_B3:                  ok = (addr == 2'd3);
         default:                  ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/rvfi_shadow_regfile.sv
// Shadow copy of the architectural register file as observed on RVFI.
// Two combinational read ports return {valid, data}; x0 is never written.
module rvfi_shadow_regfile
   import rvfi_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  rd_addr_a,
   output logic [32:0] rd_data_a,
   input  logic [4:0]  rd_addr_b,
   output logic [32:0] rd_data_b,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data
);

   logic [31:0] mem [32];
   logic [31:0] vld;
   logic        wr_go;

   assign wr_go = wr_en && (wr_addr != 5'd0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld <= '0;
      end else if (wr_go) begin
         vld[wr_addr] <= 1'b1;
      end
   end

   // Data needs no reset: an entry is only compared once its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_go) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data_a = {vld[rd_addr_a], mem[rd_addr_a]};
   assign rd_data_b = {vld[rd_addr_b], mem[rd_addr_b]};

endmodule

// File: rtl/rvfi_monitor.sv
// Single-retire RVFI consumer: checks order, PC continuity, register reads, x0 and memory masks,
// latching the first violation and counting retirements.
module rvfi_monitor
   import rvfi_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter bit          CHECK_MEM = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        rvfi_valid,
   input  logic [63:0] rvfi_order,
   input  logic [31:0] rvfi_insn,
   input  logic        rvfi_trap,
   input  logic        rvfi_halt,
   input  logic [4:0]  rvfi_rs1_addr,
   input  logic [4:0]  rvfi_rs2_addr,
   input  logic [31:0] rvfi_rs1_rdata,
   input  logic [31:0] rvfi_rs2_rdata,
   input  logic [4:0]  rvfi_rd_addr,
   input  logic [31:0] rvfi_rd_wdata,
   input  logic [31:0] rvfi_pc_rdata,
   input  logic [31:0] rvfi_pc_wdata,
   input  logic [31:0] rvfi_mem_addr,
   input  logic [3:0]  rvfi_mem_rmask,
   input  logic [3:0]  rvfi_mem_wmask,
   output logic        o_error,
   output logic [3:0]  o_err_code,
   output logic [63:0] o_err_order,
   output logic [31:0] o_err_insn,
   output logic [63:0] o_retired,
   output logic        o_halted
);

   logic [63:0] exp_order;
   logic [31:0] exp_pc;
   logic        pc_known;
   logic [32:0] rs1_shadow;
   logic [32:0] rs2_shadow;
   err_code_t   code;
   logic        bad_order, bad_pc, bad_rs1, bad_rs2, bad_rd0, bad_mask, bad_both;
   logic        unused_addr;

   // Only the byte lane of the address matters for mask legality.
   assign unused_addr = &{1'b0, rvfi_mem_addr[31:2]};

   rvfi_shadow_regfile u_shadow (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .rd_addr_a (rvfi_rs1_addr),
      .rd_data_a (rs1_shadow),
      .rd_addr_b (rvfi_rs2_addr),
      .rd_data_b (rs2_shadow),
      .wr_en     (rvfi_valid && !rvfi_trap),
      .wr_addr   (rvfi_rd_addr),
      .wr_data   (rvfi_rd_wdata)
   );

   always_comb begin
      bad_order = (rvfi_order != exp_order);
      bad_pc    = pc_known && (rvfi_pc_rdata != exp_pc);
      bad_rs1   = (rvfi_rs1_addr == 5'd0) ? (rvfi_rs1_rdata != 32'd0)
                                          : (rs1_shadow[32] && (rvfi_rs1_rdata != rs1_shadow[31:0]));
      bad_rs2   = (rvfi_rs2_addr == 5'd0) ? (rvfi_rs2_rdata != 32'd0)
                                          : (rs2_shadow[32] && (rvfi_rs2_rdata != rs2_shadow[31:0]));
      bad_rd0   = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);
      bad_mask  = CHECK_MEM && (!mask_ok(rvfi_mem_rmask, rvfi_mem_addr[1:0]) ||
                                !mask_ok(rvfi_mem_wmask, rvfi_mem_addr[1:0]));
      bad_both  = CHECK_MEM && (rvfi_mem_rmask != 4'd0) && (rvfi_mem_wmask != 4'd0);

      // Lowest code wins when several checks fail on the same packet.
      code = NONE;
      if      (bad_order) code = ORDER;
      else if (bad_pc)    code = PC;
      else if (bad_rs1)   code = RS1;
      else if (bad_rs2)   code = RS2;
      else if (bad_rd0)   code = RD0;
      else if (bad_mask)  code = MEM_MASK;
      else if (bad_both)  code = MEM_BOTH;
      else if (o_halted)  code = AFTER_HALT;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_error     <= 1'b0;
         o_err_code  <= 4'd0;
         o_err_order <= 64'd0;
         o_err_insn  <= 32'd0;
         o_retired   <= 64'd0;
         o_halted    <= 1'b0;
         exp_order   <= 64'd0;
         exp_pc      <= RESET_PC;
         pc_known    <= 1'b1;
      end else if (rvfi_valid) begin
         if (!o_error && (code != NONE)) begin
            o_error     <= 1'b1;
            o_err_code  <= code;
            o_err_order <= rvfi_order;
            o_err_insn  <= rvfi_insn;
         end
         exp_order <= rvfi_order + 64'd1;
         o_retired <= o_retired + 64'd1;
         if (rvfi_halt) o_halted <= 1'b1;
         // A trap leaves the next PC unknown; the following packet reloads it.
         if (!rvfi_trap) begin
            exp_pc   <= rvfi_pc_wdata;
            pc_known <= 1'b1;
         end else begin
            pc_known <= 1'b0;
         end
      end
   end

endmodule
